// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the memory-mapped interrupt controller.
//   - register offsets within the 8-byte window at IRQC_BASE
//   - VECTOR "no source" value
//   - helper that packs a priority-encoder result into the VECTOR byte
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam logic [2:0]  IRQC_STATUS   = 3'd0;
  localparam logic [2:0]  IRQC_MASK     = 3'd1;
  localparam logic [2:0]  IRQC_PEND     = 3'd2;
  localparam logic [2:0]  IRQC_VEC      = 3'd3;

  localparam logic [7:0]  IRQC_VEC_NONE = 8'h80;
  localparam logic [15:0] IRQC_BASE     = 16'hFE40;

  // VECTOR byte: index in [2:0] with bit 7 clear, or 8'h80 when nothing is active.
  function automatic logic [7:0] vec_byte(input logic [2:0] idx, input logic vld);
    return vld ? {5'b00000, idx} : IRQC_VEC_NONE;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index priority encoder.
// Parameters: NSRC - request width (1..8)
// Ports:
//   req  in   NSRC  request vector
//   idx  out  3     index of the lowest set bit (0 when none)
//   vld  out  1     at least one request bit is set
// ---------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic [2:0]      idx,
  output logic            vld
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = 3'd0;
    vld = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Memory-mapped interrupt controller for the 6502 system bus (8 registers at
// IRQC_BASE). Rising edges on irq_src latch into PENDING; enabled pending bits
// drive the registered CPU irq output. VECTOR returns the lowest-index active
// source so the handler needs a single read.
//
// Parameters: NSRC - number of interrupt sources (1..8); unused bits read 0.
// Optional build macro: IRQC_NMI_EN - source NSRC-1 becomes an unmaskable
//   source driving the nmi output, excluded from irq and VECTOR.
//
// Ports:
//   clk      in   1     system clock
//   rst      in   1     synchronous active-high reset
//   dbr      out  8     registered read data (valid the cycle after addr)
//   dbw      in   8     write data
//   addr     in   3     register select
//   we       in   1     write strobe (chip-select qualified)
//   irq_src  in   NSRC  rising-edge request lines, synchronous to clk
//   irq      out  1     registered CPU IRQ request, active-high
//   nmi      out  1     registered NMI request (IRQC_NMI_EN builds only)
// ---------------------------------------------------------------------------
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [7:0]      dbr,
  input  logic [7:0]      dbw,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic [NSRC-1:0] irq_src,
`ifdef IRQC_NMI_EN
  output logic            nmi,
`endif
  output logic            irq
);

  // Bit owned by the NMI path; all-zero when the feature is compiled out.
`ifdef IRQC_NMI_EN
  localparam logic [NSRC-1:0] NMI_BIT = NSRC'(1) << (NSRC - 1);
`else
  localparam logic [NSRC-1:0] NMI_BIT = '0;
`endif

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;

  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] swset;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] mask_next;
  logic [NSRC-1:0] irq_req;
  logic [NSRC-1:0] status_v;

  logic [7:0]      pend8;
  logic [7:0]      mask8;
  logic [7:0]      status8;
  logic [7:0]      rd_data;

  logic [2:0]      vec_idx;
  logic            vec_vld;

  always_comb begin
    src_edge     = irq_src & ~src_q;
    w1c          = (we && addr == IRQC_STATUS) ? dbw[NSRC-1:0] : '0;
    swset        = (we && addr == IRQC_PEND)   ? dbw[NSRC-1:0] : '0;
    mask_next    = (we && addr == IRQC_MASK)   ? dbw[NSRC-1:0] : mask;
    // A set (hardware edge or software trigger) wins over a same-cycle W1C.
    pending_next = (pending & ~w1c) | src_edge | swset;

    // Sources competing for irq and VECTOR; the NMI source never does.
    irq_req      = pending & mask & ~NMI_BIT;
    // STATUS shows the NMI source regardless of its mask bit.
    status_v     = (pending & mask) | (pending & NMI_BIT);
  end

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_enc (
    .req  (irq_req),
    .idx  (vec_idx),
    .vld  (vec_vld)
  );

  // Read mux uses current (pre-write) register values, so a read during a
  // write to the same register returns the old contents.
  always_comb begin
    pend8   = '0;
    mask8   = '0;
    status8 = '0;
    pend8[NSRC-1:0]   = pending;
    mask8[NSRC-1:0]   = mask;
    status8[NSRC-1:0] = status_v;
    case (addr)
      IRQC_STATUS: rd_data = status8;
      IRQC_MASK:   rd_data = mask8;
      IRQC_PEND:   rd_data = pend8;
      IRQC_VEC:    rd_data = vec_byte(vec_idx, vec_vld);
      default:     rd_data = 8'h00;
    endcase
  end

  // ---- register stage: edge history, state, outputs ----
  // src_q tracks irq_src even in reset so a line already high at release
  // does not look like a fresh edge.
  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      irq     <= 1'b0;
      dbr     <= 8'h00;
`ifdef IRQC_NMI_EN
      nmi     <= 1'b0;
`endif
    end else begin
      pending <= pending_next;
      mask    <= mask_next;
      // irq follows the registered pending/mask, one edge behind them.
      irq     <= |irq_req;
      dbr     <= rd_data;
`ifdef IRQC_NMI_EN
      nmi     <= |(pending & NMI_BIT);
`endif
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [2:0] addr;
  logic       we;
  logic [7:0] irq_src;
  logic       irq;
`ifdef IRQC_NMI_EN
  logic       nmi;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.NSRC(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .dbr     (dbr),
    .dbw     (dbw),
    .addr    (addr),
    .we      (we),
    .irq_src (irq_src),
`ifdef IRQC_NMI_EN
    .nmi     (nmi),
`endif
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a;
    dbw  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    dbw  = 8'h00;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    addr = a;
    we   = 1'b0;
    tick();
    v = dbr;
  endtask

  logic [7:0] v;

  initial begin
    rst = 1'b1; we = 1'b0; addr = 3'd0; dbw = 8'h00; irq_src = 8'h04;
    repeat (3) tick();
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_dbr", dbr, 8'h00);
    rst = 1'b0;
    tick();
    // Line held high through reset release: no edge.
    chk("post_rst_irq", {7'b0, irq}, 8'h00);
    rd(3'd2, v); chk("post_rst_pend", v, 8'h00);
    rd(3'd3, v); chk("post_rst_vec", v, 8'h80);
    rd(3'd0, v); chk("post_rst_status", v, 8'h00);
    rd(3'd1, v); chk("post_rst_mask", v, 8'h00);

    // Enabled source 2: irq two edges after rise, then W1C drops it.
    irq_src = 8'h00; tick();
    wr(3'd1, 8'h04);
    irq_src = 8'h04;
    tick(); tick();
    chk("src2_irq", {7'b0, irq}, 8'h01);
    rd(3'd0, v); chk("src2_status", v, 8'h04);
    rd(3'd3, v); chk("src2_vec", v, 8'h02);
    wr(3'd0, 8'h04);
    tick();
    chk("src2_w1c_irq", {7'b0, irq}, 8'h00);
    tick(); tick();
    rd(3'd2, v); chk("src2_level_no_retrig", v, 8'h00);

    // Masked source 5 pends silently, then unmasking raises irq.
    wr(3'd1, 8'h00);
    irq_src = 8'h24;
    tick(); tick();
    chk("src5_masked_irq", {7'b0, irq}, 8'h00);
    rd(3'd2, v); chk("src5_pend", v, 8'h20);
    rd(3'd0, v); chk("src5_status", v, 8'h00);
    wr(3'd1, 8'h20);
    tick();
    chk("src5_unmask_irq", {7'b0, irq}, 8'h01);

    // Priority walk over bits 1, 3, 6.
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'hFF);
    wr(3'd2, 8'h4A);
    rd(3'd2, v); chk("prio_pend", v, 8'h4A);
    rd(3'd3, v); chk("prio_vec_a", v, 8'h01);
    wr(3'd0, 8'h02);
    rd(3'd3, v); chk("prio_vec_b", v, 8'h03);
    wr(3'd0, 8'h08);
    rd(3'd3, v); chk("prio_vec_c", v, 8'h06);
    wr(3'd0, 8'h40);
    rd(3'd3, v); chk("prio_vec_none", v, 8'h80);
    tick();
    chk("prio_irq_off", {7'b0, irq}, 8'h00);

    // Read during write to MASK returns the old value.
    addr = 3'd1; dbw = 8'h0F; we = 1'b1;
    tick();
    we = 1'b0;
    chk("rdw_mask_old", dbr, 8'hFF);
    rd(3'd1, v); chk("rdw_mask_new", v, 8'h0F);
    wr(3'd1, 8'hFF);

    // Hardware edge on src 0 coincides with W1C of bit 0: set wins.
    irq_src = 8'h25; addr = 3'd0; dbw = 8'h01; we = 1'b1;
    tick();
    we = 1'b0;
    rd(3'd2, v); chk("edge_vs_w1c_pend", v, 8'h01);
    chk("edge_vs_w1c_irq", {7'b0, irq}, 8'h01);

    // Software trigger, unused addresses, ignored VECTOR write.
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h10);
    wr(3'd2, 8'h10);
    tick();
    chk("swtrig_irq", {7'b0, irq}, 8'h01);
    rd(3'd2, v); chk("swtrig_pend", v, 8'h10);
    wr(3'd3, 8'h55);
    rd(3'd3, v); chk("vec_wr_ignored", v, 8'h04);
    wr(3'd4, 8'hFF);
    rd(3'd4, v); chk("addr4_zero", v, 8'h00);
    rd(3'd7, v); chk("addr7_zero", v, 8'h00);
    rd(3'd2, v); chk("addr4_wr_no_effect", v, 8'h10);

    // Reset mid-activity.
    addr = 3'd2;
    rst = 1'b1;
    tick();
    chk("midrst_irq", {7'b0, irq}, 8'h00);
    chk("midrst_dbr", dbr, 8'h00);
    rst = 1'b0;
    rd(3'd1, v); chk("midrst_mask", v, 8'h00);
    rd(3'd2, v); chk("midrst_pend", v, 8'h00);
    chk("midrst_irq_after", {7'b0, irq}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
